// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - one ALU shared by NREQ requesters, registered tagged response
// Optional round-robin arbitration via ALU_SHARE_ARB_RR_EN; fixed lowest-index priority otherwise.
module alu_share_arbiter #(
    parameter int NREQ  = 2,
    parameter int ID_W  = 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic                 stall,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [31:0]          resp_result,
    output logic                 resp_zero,
    output logic [CNT_W-1:0]     conflict_cnt
);

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic            found;
    logic            xfer;
    logic            multi_req;
    int              scan_idx;
    int              sel;
    logic [2:0]      alu_op;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [31:0]     alu_y;

`ifdef ALU_SHARE_ARB_RR_EN
    logic [ID_W-1:0] last_id;
`endif

    // Scan starts just after the last winner (round-robin) or at index 0 (fixed priority).
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_SHARE_ARB_RR_EN
            scan_idx = (int'(last_id) + k + 1) % NREQ;
`else
            scan_idx = k;
`endif
            if (!found && req_valid[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_id        = ID_W'(scan_idx);
            end
        end
    end

    assign req_ready = (rst || stall) ? '0 : grant;
    assign xfer      = found && !stall && !rst;
    assign multi_req = $countones(req_valid) > 1;

    always_comb begin
        sel    = int'(grant_id);
        alu_op = req_op[3*sel +: 3];
        alu_a  = req_a[32*sel +: 32];
        alu_b  = req_b[32*sel +: 32];
        alu_y  = '0;
        case (alu_op)
            3'b000: alu_y = alu_a | alu_b;
            3'b001: alu_y = alu_a & alu_b;
            3'b010: alu_y = alu_a ^ alu_b;
            3'b011: alu_y = alu_a + alu_b;
            3'b100: alu_y = ~(alu_a | alu_b);
            3'b101: alu_y = ~(alu_a & alu_b);
            3'b110: alu_y = {31'd0, alu_a < alu_b};
            default: alu_y = alu_a - alu_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_result  <= '0;
            resp_zero    <= 1'b0;
            conflict_cnt <= '0;
`ifdef ALU_SHARE_ARB_RR_EN
            last_id      <= ID_W'(NREQ-1);
`endif
        end else begin
            resp_valid <= xfer;
            if (xfer) begin
                resp_id     <= grant_id;
                resp_result <= alu_y;
                resp_zero   <= (alu_y == 32'd0);
`ifdef ALU_SHARE_ARB_RR_EN
                last_id     <= grant_id;
`endif
            end
            if (!stall && multi_req && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule
